// File: rtl/alu_pkg.sv
// Shared op-code and FSM state encodings for the bit-serial ALU sequencer.
`default_nettype none

package alu_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_slice_1bit.sv
// One-bit ALU slice: AND / OR / SUM selected by a 2:1 mux tree, majority carry.
`default_nettype none

module alu_slice_1bit (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] sel,
  output logic       y,
  output logic       cout
);

  logic sum;
  logic m_lo;
  logic m_hi;

  assign sum  = a ^ b ^ cin;
  // SUB shares the ADD leg; inversion of B happens in the controller.
  assign m_lo = sel[0] ? (a | b) : (a & b);
  assign m_hi = sel[0] ? sum : sum;
  assign y    = sel[1] ? m_hi : m_lo;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

`default_nettype wire

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: feeds operands LSB-first through a 1-bit slice
// and reassembles the parallel result with carry, zero and overflow flags.
`default_nettype none

module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             cmsb_q, cmsb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             slice_y;
  logic             slice_co;
  logic             is_arith;

  alu_slice_1bit u_slice (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0] ^ (op_q == OP_SUB)),
    .cin  (carry_q),
    .sel  (op_q),
    .y    (slice_y),
    .cout (slice_co)
  );

  assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    result_d = result_q;
    carry_d  = carry_q;
    cmsb_d   = cmsb_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cout_d   = cout_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        // Busy stays up through the registered done cycle, which blocks a new accept.
        if (done_q) begin
          busy_d = 1'b0;
        end else if (start && !busy_q) begin
          state_d = S_SHIFT;
          op_d    = op_e'(op);
          a_sr_d  = a;
          b_sr_d  = b;
          cnt_d   = '0;
          carry_d = (op_e'(op) == OP_SUB);
          busy_d  = 1'b1;
        end
      end
      S_SHIFT: begin
        res_sr_d = {slice_y, res_sr_q[WIDTH-1:1]};
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        carry_d  = slice_co;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cmsb_d  = carry_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        done_d   = 1'b1;
        result_d = res_sr_q;
        zero_d   = (res_sr_q == '0);
        cout_d   = is_arith & carry_q;
        ovf_d    = is_arith & (carry_q ^ cmsb_q);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_AND;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cmsb_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cmsb_q   <= cmsb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;

endmodule

`default_nettype wire
